uart_tx_fifo: RTL

Transmit-side byte buffer between the APB-facing UART register block and the UART transmitter.
- The register block pushes bytes in.
- This block pops one byte at a time, presents it on TxData, pulses TxStart, and waits for the transmitter's TxDone before sending the next byte.
- This lets software queue up to DEPTH bytes without polling per byte, and reports fill level and overflow for status/IRQ logic.

---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue between the UART register block and the transmitter.
// Bytes are pushed by software and handed one at a time to the transmitter.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              clr_ovf,
  input  logic              TxDone,
  output logic              TxStart,
  output logic [7:0]        TxData,
  output logic              tx_busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  // Transmitter handshake: TxStart is a one-cycle request that carries
  // TxData. TxData then holds until the first rising edge of TxDone seen in
  // WAIT. tx_busy spans START through WAIT. Push side: wr_en is a
  // fire-and-forget valid, accepted unless the queue is full with no pop.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              tx_done_q, tx_done_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic pop;
  logic push_acc;
  logic push_drop;
  logic done_evt;
  logic full_w;
  logic empty_w;

  assign full_w   = (count_q == DEPTH_C);
  assign empty_w  = (count_q == '0);
  assign done_evt = TxDone && !tx_done_q;

  // A pop frees a slot in the same cycle, so a full queue still takes a push.
  always_comb begin
    pop       = (state_q == ST_IDLE) && !empty_w;
    push_acc  = wr_en && !flush && (!full_w || pop);
    push_drop = wr_en && !flush && full_w && !pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;
    tx_done_d  = TxDone;

    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_acc, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    if (push_drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_done_q  <= tx_done_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage holds no reset: stale entries are never read before being written.
  always_ff @(posedge pClk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (done_evt) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    TxStart = 1'b0;
    tx_busy = 1'b0;
    case (state_q)
      ST_START: begin
        TxStart = 1'b1;
        tx_busy = 1'b1;
      end
      ST_WAIT:  tx_busy = 1'b1;
      default:  ;
    endcase
  end

  assign TxData    = tx_data_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule
